seg_scan_mux: RTL and testbench

SEG_SCAN_MUX -- requirements
Module: seg_scan_mux

---
 rtl/seg_pkg.sv | 11 +
 rtl/hex7seg.sv | 9 +
 rtl/seg_scan_mux.sv | 81 ++++++++
 tb/tb_seg_scan_mux.sv | 133 +++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: shared constants, FSM state type and active-low hex glyph table for seg_scan_mux
package seg_pkg;
  localparam int NUM_DIGITS = 4;
  localparam logic [6:0] SEG_OFF = 7'h7F;
  typedef enum logic {BLANK, DRIVE} state_t;
  // index = nibble, bit 0 = segment a, 0 = lit
  localparam logic [6:0] GLYPH [0:15] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
endpackage

// File: rtl/hex7seg.sv
// hex7seg: combinational nibble to active-low 7-segment glyph
module hex7seg
  import seg_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);
  assign seg_o = GLYPH[nib_i];
endmodule

// File: rtl/seg_scan_mux.sv
// seg_scan_mux: 4-digit multiplexed 7-seg scanner with anti-ghost blanking; SEG_SCAN_LEADING_ZERO_BLANK_EN darkens leading zeros
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [15:0]           value,
  input  logic [NUM_DIGITS-1:0] dig_en,
  input  logic                  ovf,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [NUM_DIGITS-1:0] AN,
  output logic                  frame_done
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLK  = CW'(BLANK_CYCLES);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] dig_q, dig_d;
  state_t state_q, state_d;
  logic [15:0] val_q;
  logic [NUM_DIGITS-1:0] en_q, an_q;
  logic ovf_q, dp_q, fd_q, lit, lz;
  logic [6:0] seg_q, glyph;
  logic [3:0] nib;
  hex7seg u_hex (.nib_i(nib), .seg_o(glyph));
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
  assign lz = (dig_d != 2'd0) && ((val_q >> {dig_d, 2'b00}) == 16'h0);
`else
  assign lz = 1'b0;
`endif
  // next-state values describe the slot position being entered, so outputs line up with cnt_q
  always_comb begin
    cnt_d   = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    dig_d   = (cnt_q == LAST) ? dig_q + 2'd1 : dig_q;
    state_d = (cnt_d < BLK) ? BLANK : DRIVE;
    nib     = val_q[{dig_d, 2'b00} +: 4];
    lit     = en_q[dig_d] && !lz;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      dig_q   <= '0;
      state_q <= BLANK;
      val_q   <= '0;
      en_q    <= '0;
      ovf_q   <= 1'b0;
      an_q    <= '1;
      seg_q   <= SEG_OFF;
      dp_q    <= 1'b1;
      fd_q    <= 1'b0;
    end else begin
      if (load) begin
        val_q <= value;
        en_q  <= dig_en;
        ovf_q <= ovf;
      end
      cnt_q   <= cnt_d;
      dig_q   <= dig_d;
      state_q <= state_d;
      fd_q    <= (dig_d == 2'd3) && (cnt_d == LAST);
      if (state_d == BLANK) begin
        an_q  <= '1;
        seg_q <= SEG_OFF;
        dp_q  <= 1'b1;
      end else if (state_q == BLANK) begin
        an_q  <= lit ? ~(4'b0001 << dig_d) : 4'hF;
        seg_q <= lit ? glyph : SEG_OFF;
        dp_q  <= ~(lit && (dig_d == 2'd0) && ovf_q);
      end
    end
  end
  assign AN         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = fd_q;
endmodule

// File: tb/tb_seg_scan_mux.sv
// tb_seg_scan_mux: scoreboard bench, REFRESH_DIV=8 BLANK_CYCLES=2, frame = 32 cycles
module tb_seg_scan_mux;
  logic clk = 1'b0, rst = 1'b1, load = 1'b0, ovf = 1'b0;
  logic [15:0] value = '0;
  logic [3:0] dig_en = '0;
  logic [6:0] seg;
  logic dp, frame_done;
  logic [3:0] AN;
  typedef struct {
    string      tag;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
  } exp_t;
  exp_t sb[$];
  int tests = 0, fails = 0, t = 0;
  string phase = "reset";
  logic [15:0] sh_v = '0, lat_v = '0;
  logic [3:0] sh_e = '0, lat_e = '0;
  logic sh_o = 1'b0, lat_o = 1'b0;
  logic [6:0] gl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  always #5 clk = ~clk;
  seg_scan_mux #(.REFRESH_DIV(8), .BLANK_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .load(load), .value(value), .dig_en(dig_en), .ovf(ovf),
    .seg(seg), .dp(dp), .AN(AN), .frame_done(frame_done)
  );
  function automatic exp_t expect_at(int tt);
    exp_t e;
    int d = tt / 8;
    logic lit, lz;
    lz = 1'b0;
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
    lz = (d != 0) && ((lat_v >> (4 * d)) == 16'h0);
`endif
    lit = lat_e[d] && !lz;
    e.tag = phase;
    e.an = 4'hF;
    e.seg = 7'h7F;
    e.dp = 1'b1;
    e.fd = (tt == 31);
    if (tt % 8 >= 2 && lit) begin
      e.an = ~(4'b0001 << d);
      e.seg = gl[lat_v[4*d +: 4]];
      e.dp = !(d == 0 && lat_o);
    end
    return e;
  endfunction
  task automatic cyc();
    @(posedge clk);
    if (rst) begin
      t = 0;
      sh_v = '0; sh_e = '0; sh_o = 1'b0;
      lat_v = '0; lat_e = '0; lat_o = 1'b0;
    end else begin
      t = (t + 1) % 32;
      if (t % 8 == 2) begin
        lat_v = sh_v; lat_e = sh_e; lat_o = sh_o;
      end
      if (load) begin
        sh_v = value; sh_e = dig_en; sh_o = ovf;
      end
    end
    sb.push_back(expect_at(t));
    #1;
    load = 1'b0;
  endtask
  task automatic run(int n);
    for (int i = 0; i < n; i++) cyc();
  endtask
  task automatic load_set(logic [15:0] v, logic [3:0] e, logic o);
    value = v; dig_en = e; ovf = o; load = 1'b1;
    cyc();
  endtask
  task automatic wait_t(int target);
    for (int i = 0; i < 64 && t != target; i++) cyc();
  endtask
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      tests++;
      if ({AN, seg, dp, frame_done} !== {e.an, e.seg, e.dp, e.fd}) begin
        fails++;
        $display("FAIL %s @%0t: got AN=%b seg=%h dp=%b fd=%b, want AN=%b seg=%h dp=%b fd=%b",
                 e.tag, $time, AN, seg, dp, frame_done, e.an, e.seg, e.dp, e.fd);
      end
    end
  end
  initial begin
    rst = 1'b1;
    run(3);
    rst = 1'b0;
    phase = "scan";
    load_set(16'h1234, 4'hF, 1'b0);
    run(40);
    phase = "midload";
    wait_t(11);
    load_set(16'hFFFF, 4'hF, 1'b0);
    run(40);
    phase = "dig_en";
    load_set(16'h1234, 4'b0101, 1'b1);
    run(40);
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
    phase = "lz_0000";
    load_set(16'h0000, 4'hF, 1'b0);
    run(40);
    phase = "lz_00A0";
    load_set(16'h00A0, 4'hF, 1'b0);
    run(40);
`endif
    phase = "rst_mid";
    load_set(16'hABCD, 4'hF, 1'b1);
    wait_t(19);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    run(12);
    phase = "after_rst";
    load_set(16'h0000, 4'h1, 1'b0);
    run(40);
    @(negedge clk);
    #1;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
